// File: rtl/tristate_bus_reader_pkg.sv
// Shared state encoding, counter width and sizing helper for the tristate bus reader.
// Pure declarations: no logic, no latency, no backpressure.
package tristate_bus_reader_pkg;

  typedef enum logic [1:0] {
    S_IDLE    = 2'd0,
    S_SELECT  = 2'd1,
    S_CAPTURE = 2'd2,
    S_HOLD    = 2'd3
  } state_t;

  localparam int CntBits = 4;

  function automatic int clog2(input int value);
    int result;
    result = 0;
    while ((1 << result) < value) result++;
    return result;
  endfunction

endpackage

// File: rtl/tristate_bus_reader_settle_counter.sv
// Tick-enabled settle down-counter; done flags the last Tick of the settle window.
// Load wins over decrement; counter parks at zero once expired.
module bus_settle_counter
  import tristate_bus_reader_pkg::*;
(
  input  logic               Clock,
  input  logic               Reset,
  input  logic               Tick,
  input  logic               load,
  input  logic [CntBits-1:0] load_val,
  output logic               done
);

  logic [CntBits-1:0] cnt;

  always_ff @(posedge Clock) begin
    if (Reset) begin
      cnt <= '0;
    end else if (load) begin
      cnt <= load_val;
    end else if (Tick && (cnt != '0)) begin
      cnt <= cnt - CntBits'(1);
    end
  end

  assign done = (cnt == CntBits'(1)) && Tick;

endmodule

// File: rtl/tristate_bus_reader.sv
// Selects one tristate register, waits SettleCycles Ticks, captures the bus; valid at accept+SettleCycles+1.
// Result held in HOLD until rd_ready (no Tick needed); requests while busy are dropped.
module tristate_bus_reader
  import tristate_bus_reader_pkg::*;
#(
  parameter int NrOfBits     = 8,
  parameter int NrOfRegs     = 4,
  parameter int AddrBits     = 2,
  parameter int SettleCycles = 1
) (
  input  logic                Clock,
  input  logic                Reset,
  input  logic                Tick,
  input  logic                rd_req,
  input  logic [AddrBits-1:0] rd_addr,
  output logic                rd_busy,
  output logic [NrOfRegs-1:0] cs,
  input  logic [NrOfBits-1:0] bus,
  output logic [NrOfBits-1:0] rd_data,
  output logic                rd_valid,
  input  logic                rd_ready,
  output logic                rd_err
);

  state_t              state, state_nxt;
  logic [AddrBits-1:0] addr_q;
  logic [AddrBits-1:0] sel_addr;
  logic [NrOfRegs-1:0] cs_nxt;
  logic                addr_ok;
  logic                cnt_load;
  logic                cnt_done;

  assign addr_ok = (32'(rd_addr) < NrOfRegs);
  assign rd_busy = (state != S_IDLE);

  bus_settle_counter u_settle (
    .Clock    (Clock),
    .Reset    (Reset),
    .Tick     (Tick),
    .load     (cnt_load),
    .load_val (CntBits'(SettleCycles)),
    .done     (cnt_done)
  );

  always_comb begin
    state_nxt = state;
    cnt_load  = 1'b0;
    case (state)
      S_IDLE: begin
        if (Tick && rd_req && addr_ok) begin
          state_nxt = S_SELECT;
          cnt_load  = 1'b1;
        end
      end
      S_SELECT:  if (cnt_done) state_nxt = S_CAPTURE;
      S_CAPTURE: if (Tick)     state_nxt = S_HOLD;
      S_HOLD:    if (rd_ready) state_nxt = S_IDLE;
      default:   state_nxt = S_IDLE;
    endcase
  end

  // Select decode is computed from the next state so at most one cs bit can ever be low.
  always_comb begin
    sel_addr = (state == S_IDLE) ? rd_addr : addr_q;
    cs_nxt   = '1;
    if ((state_nxt == S_SELECT) || (state_nxt == S_CAPTURE)) begin
      for (int i = 0; i < NrOfRegs; i++) begin
        cs_nxt[i] = (32'(sel_addr) != i);
      end
    end
  end

  always_ff @(posedge Clock) begin
    if (Reset) begin
      state    <= S_IDLE;
      addr_q   <= '0;
      cs       <= '1;
      rd_data  <= '0;
      rd_valid <= 1'b0;
      rd_err   <= 1'b0;
    end else begin
      state  <= state_nxt;
      cs     <= cs_nxt;
      rd_err <= (state == S_IDLE) && Tick && rd_req && !addr_ok;
      if (cnt_load) begin
        addr_q <= rd_addr;
      end
      if ((state == S_CAPTURE) && Tick) begin
        rd_data  <= bus;
        rd_valid <= 1'b1;
      end else if ((state == S_HOLD) && rd_ready) begin
        rd_valid <= 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_tristate_bus_reader.sv
// Directed bench: two reader instances (SettleCycles 1 and 2) over a modelled 4-register tristate bus.
module tb_tristate_bus_reader;

  logic       Clock = 1'b0;
  logic       Reset;
  logic [7:0] regs [4];

  logic       a_tick, a_req, a_busy, a_valid, a_ready, a_err;
  logic [2:0] a_addr;
  logic [3:0] a_cs;
  logic [7:0] a_bus, a_data;

  logic       b_tick, b_req, b_busy, b_valid, b_ready, b_err;
  logic [1:0] b_addr;
  logic [3:0] b_cs;
  logic [7:0] b_bus, b_data;

  int checks = 0;
  int errors = 0;
  logic       mon_en = 1'b0;
  logic       prev_hold = 1'b0;
  logic [7:0] prev_data = 8'h00;

  always #5 Clock = ~Clock;

  // Tristate bus model: selected register drives, otherwise floating (reads as 0).
  always_comb begin
    a_bus = 8'h00;
    b_bus = 8'h00;
    for (int i = 0; i < 4; i++) begin
      if (!a_cs[i]) a_bus = regs[i];
      if (!b_cs[i]) b_bus = regs[i];
    end
  end

  tristate_bus_reader #(.NrOfBits(8), .NrOfRegs(4), .AddrBits(3), .SettleCycles(1)) dut_a (
    .Clock(Clock), .Reset(Reset), .Tick(a_tick), .rd_req(a_req), .rd_addr(a_addr),
    .rd_busy(a_busy), .cs(a_cs), .bus(a_bus), .rd_data(a_data), .rd_valid(a_valid),
    .rd_ready(a_ready), .rd_err(a_err)
  );

  tristate_bus_reader #(.NrOfBits(8), .NrOfRegs(4), .AddrBits(2), .SettleCycles(2)) dut_b (
    .Clock(Clock), .Reset(Reset), .Tick(b_tick), .rd_req(b_req), .rd_addr(b_addr),
    .rd_busy(b_busy), .cs(b_cs), .bus(b_bus), .rd_data(b_data), .rd_valid(b_valid),
    .rd_ready(b_ready), .rd_err(b_err)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge Clock);
    #1;
  endtask

  // Continuous invariants: one-hot-low select, released when not reading, data stable under backpressure.
  always @(negedge Clock) begin
    if (mon_en) begin
      chk("a_cs_onehot", 32'($countones(~a_cs) <= 1), 32'd1);
      chk("b_cs_onehot", 32'($countones(~b_cs) <= 1), 32'd1);
      if (!a_busy || a_valid) chk("a_cs_released", 32'(a_cs), 32'hF);
      if (prev_hold) chk("a_data_stable", 32'(a_data), 32'(prev_data));
      prev_hold = a_valid && !a_ready;
      prev_data = a_data;
    end
  end

  initial begin
    logic [7:0] exp_tbl [4];
    exp_tbl[0] = 8'hA1; exp_tbl[1] = 8'hB2; exp_tbl[2] = 8'hC3; exp_tbl[3] = 8'hD4;
    regs[0] = 8'hA1; regs[1] = 8'hB2; regs[2] = 8'hC3; regs[3] = 8'hD4;
    Reset = 1'b1;
    a_tick = 1'b1; a_req = 1'b0; a_addr = 3'd0; a_ready = 1'b1;
    b_tick = 1'b1; b_req = 1'b0; b_addr = 2'd0; b_ready = 1'b1;
    step(); step();
    chk("rst_cs",    32'(a_cs), 32'hF);
    chk("rst_valid", 32'(a_valid), 32'd0);
    chk("rst_busy",  32'(a_busy), 32'd0);
    chk("rst_data",  32'(a_data), 32'd0);
    chk("rst_err",   32'(a_err), 32'd0);
    Reset = 1'b0;
    mon_en = 1'b1;

    // 1: single read of register 2
    a_req = 1'b1; a_addr = 3'd2;
    step();
    a_req = 1'b0;
    chk("t1_cs_c1",    32'(a_cs), 32'hB);
    chk("t1_busy",     32'(a_busy), 32'd1);
    chk("t1_valid_c1", 32'(a_valid), 32'd0);
    step();
    chk("t1_cs_c2",    32'(a_cs), 32'hB);
    chk("t1_valid_c2", 32'(a_valid), 32'd0);
    step();
    chk("t1_valid", 32'(a_valid), 32'd1);
    chk("t1_data",  32'(a_data), 32'hC3);
    chk("t1_cs_rel", 32'(a_cs), 32'hF);
    step();
    chk("t1_done_valid", 32'(a_valid), 32'd0);
    chk("t1_done_busy",  32'(a_busy), 32'd0);

    // 2: back-to-back reads 0..3
    for (int i = 0; i < 4; i++) begin
      a_req = 1'b1; a_addr = 3'(i);
      step();
      a_req = 1'b0;
      chk("t2_accept_busy", 32'(a_busy), 32'd1);
      step(); step();
      chk("t2_valid", 32'(a_valid), 32'd1);
      chk("t2_data",  32'(a_data), 32'(exp_tbl[i]));
      step();
      chk("t2_gap_cs", 32'(a_cs), 32'hF);
    end

    // 3: out-of-range address
    a_req = 1'b1; a_addr = 3'd5;
    step();
    a_req = 1'b0;
    chk("t3_err",  32'(a_err), 32'd1);
    chk("t3_cs",   32'(a_cs), 32'hF);
    chk("t3_busy", 32'(a_busy), 32'd0);
    step();
    chk("t3_err_pulse", 32'(a_err), 32'd0);
    chk("t3_busy2",     32'(a_busy), 32'd0);

    // 4: backpressure in HOLD while registers change and new requests arrive
    a_ready = 1'b0; a_req = 1'b1; a_addr = 3'd1;
    step();
    a_req = 1'b0;
    step(); step();
    chk("t4_valid", 32'(a_valid), 32'd1);
    chk("t4_data",  32'(a_data), 32'hB2);
    regs[0] = 8'h11; regs[1] = 8'h22; regs[2] = 8'h33; regs[3] = 8'h44;
    for (int i = 0; i < 5; i++) begin
      a_req = 1'b1; a_addr = 3'd0;
      step();
      chk("t4_hold_valid", 32'(a_valid), 32'd1);
      chk("t4_hold_data",  32'(a_data), 32'hB2);
      chk("t4_hold_cs",    32'(a_cs), 32'hF);
    end
    a_req = 1'b0; a_ready = 1'b1;
    step();
    chk("t4_exit_valid", 32'(a_valid), 32'd0);
    chk("t4_exit_busy",  32'(a_busy), 32'd0);
    step();
    chk("t4_not_queued", 32'(a_busy), 32'd0);

    // 5: Tick pattern 1,0,0,1 during SELECT with SettleCycles=2
    b_req = 1'b1; b_addr = 2'd0;
    step();
    b_req = 1'b0;
    chk("t5_cs", 32'(b_cs), 32'hE);
    step();
    b_tick = 1'b0;
    step(); step();
    chk("t5_frozen_cs",    32'(b_cs), 32'hE);
    chk("t5_frozen_valid", 32'(b_valid), 32'd0);
    b_tick = 1'b1;
    step();
    chk("t5_capture_valid", 32'(b_valid), 32'd0);
    chk("t5_capture_cs",    32'(b_cs), 32'hE);
    step();
    chk("t5_valid", 32'(b_valid), 32'd1);
    chk("t5_data",  32'(b_data), 32'h11);
    step();
    chk("t5_idle", 32'(b_busy), 32'd0);

    // 6: reset during SELECT, then a clean read
    a_req = 1'b1; a_addr = 3'd3;
    step();
    a_req = 1'b0;
    chk("t6_sel_cs", 32'(a_cs), 32'h7);
    Reset = 1'b1;
    step();
    chk("t6_rst_cs",    32'(a_cs), 32'hF);
    chk("t6_rst_busy",  32'(a_busy), 32'd0);
    chk("t6_rst_valid", 32'(a_valid), 32'd0);
    Reset = 1'b0;
    a_req = 1'b1; a_addr = 3'd3;
    step();
    a_req = 1'b0;
    step(); step();
    chk("t6_valid", 32'(a_valid), 32'd1);
    chk("t6_data",  32'(a_data), 32'h44);
    step();
    chk("t6_idle", 32'(a_busy), 32'd0);

    mon_en = 1'b0;
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
